// File: rtl/btn_event_arbiter_pkg.sv
// Shared definitions for the button event arbiter.
//   - event-type codes carried on evt_type
//   - per-button debounce FSM state encoding
//   - clog2 helper used for counter and index widths
package btn_event_arbiter_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_RELEASE = 2'd1;
  localparam logic [1:0] EVT_LONG    = 2'd2;

  typedef enum logic [2:0] {
    ST_RELEASED     = 3'd0,
    ST_PRESS_PEND   = 3'd1,
    ST_PRESSED      = 3'd2,
    ST_LONG_HELD    = 3'd3,
    ST_RELEASE_PEND = 3'd4
  } btn_state_t;

  // Ceiling log2, never less than 1 so it can always size a vector.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/btn_fsm.sv
// One button: 2-FF synchronizer followed by the press / long-press /
// release debounce FSM. The FSM only advances on cycles where the shared
// sample tick is high.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   btn         raw asynchronous button level (1 = pressed)
//   tick        one-cycle sample strobe from the shared prescaler
//   level       debounced level (registered)
//   evt_strobe  high on the tick cycle that commits an event (combinational)
//   evt_type    type of that event, valid while evt_strobe is high
module btn_fsm
  import btn_event_arbiter_pkg::*;
#(
  parameter int STABLE_TICKS = 16,
  parameter int LONG_TICKS   = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       tick,
  output logic       level,
  output logic       evt_strobe,
  output logic [1:0] evt_type
);

  localparam int CNT_W = clog2(LONG_TICKS + 1);
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_TICKS);
  localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  logic             sync_meta;
  logic             s;
  btn_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic             long_done, long_done_next;
  logic             level_next;
  logic             do_press, do_release, start_release;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      s         <= 1'b0;
    end else begin
      sync_meta <= btn;
      s         <= sync_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RELEASED;
      cnt       <= '0;
      long_done <= 1'b0;
      level     <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      long_done <= long_done_next;
      level     <= level_next;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    long_done_next = long_done;
    level_next     = level;
    evt_strobe     = 1'b0;
    evt_type       = EVT_PRESS;
    do_press       = 1'b0;
    do_release     = 1'b0;
    start_release  = 1'b0;
    cnt_inc        = cnt + ONE_C;

    if (tick) begin
      case (state)
        ST_RELEASED: begin
          if (s) begin
            // First matching tick counts as 1; with STABLE_TICKS=1 it commits.
            if (STABLE_C <= ONE_C) begin
              do_press = 1'b1;
            end else begin
              state_next = ST_PRESS_PEND;
              cnt_next   = ONE_C;
            end
          end
        end
        ST_PRESS_PEND: begin
          if (s) begin
            if (cnt_inc >= STABLE_C) do_press = 1'b1;
            else                     cnt_next = cnt_inc;
          end else begin
            state_next = ST_RELEASED;
            cnt_next   = '0;
          end
        end
        ST_PRESSED: begin
          if (s) begin
            if (cnt_inc >= LONG_C) begin
              state_next     = ST_LONG_HELD;
              cnt_next       = '0;
              long_done_next = 1'b1;
              evt_strobe     = 1'b1;
              evt_type       = EVT_LONG;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            start_release = 1'b1;
          end
        end
        ST_LONG_HELD: begin
          if (!s) start_release = 1'b1;
        end
        ST_RELEASE_PEND: begin
          if (!s) begin
            if (cnt_inc >= STABLE_C) do_release = 1'b1;
            else                     cnt_next = cnt_inc;
          end else begin
            // Bounce back: a completed long press never repeats its LONG event,
            // otherwise the long-press timer restarts from zero.
            state_next = long_done ? ST_LONG_HELD : ST_PRESSED;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = ST_RELEASED;
          cnt_next   = '0;
        end
      endcase

      if (start_release) begin
        if (STABLE_C <= ONE_C) begin
          do_release = 1'b1;
        end else begin
          state_next = ST_RELEASE_PEND;
          cnt_next   = ONE_C;
        end
      end

      if (do_press) begin
        state_next     = ST_PRESSED;
        cnt_next       = '0;
        long_done_next = 1'b0;
        level_next     = 1'b1;
        evt_strobe     = 1'b1;
        evt_type       = EVT_PRESS;
      end

      if (do_release) begin
        state_next = ST_RELEASED;
        cnt_next   = '0;
        level_next = 1'b0;
        evt_strobe = 1'b1;
        evt_type   = EVT_RELEASE;
      end
    end
  end

endmodule

// File: rtl/btn_event_arbiter.sv
// Debounces N_BTN buttons with one shared sample-tick prescaler and merges
// their PRESS / RELEASE / LONG events into a single event stream.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   btn         raw button levels, 1 = pressed
//   btn_level   debounced level per button
//   evt_valid   output slot holds an event
//   evt_ready   consumer ready
//   evt_btn     index of the button that produced the event
//   evt_type    0 = PRESS, 1 = RELEASE, 2 = LONG
//   evt_drop    one-cycle pulse when an event is lost
//
// Handshake: an event transfers on every clock edge where evt_valid and
// evt_ready are both high. While evt_valid is high and evt_ready is low,
// evt_btn/evt_type hold. evt_ready may stay high permanently; ready without
// valid has no effect. A new event loads in the same cycle the old one is
// accepted, so a busy stream has no bubbles.
module btn_event_arbiter
  import btn_event_arbiter_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 16,
  parameter int LONG_TICKS   = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_BTN-1:0]          btn,
  output logic [N_BTN-1:0]          btn_level,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [clog2(N_BTN)-1:0]   evt_btn,
  output logic [1:0]                evt_type,
  output logic                      evt_drop
);

  localparam int IDX_W = clog2(N_BTN);
  localparam int DIV_W = clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BTN - 1);

  // Shared sample-tick prescaler.
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  // Per-button debounce FSMs.
  logic [N_BTN-1:0] fsm_strobe;
  logic [1:0]       fsm_type [N_BTN];

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_fsm #(
      .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS  (LONG_TICKS)
    ) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn       (btn[g]),
      .tick      (tick),
      .level     (btn_level[g]),
      .evt_strobe(fsm_strobe[g]),
      .evt_type  (fsm_type[g])
    );
  end

  // Pending store and round-robin selection.
  logic [N_BTN-1:0] pend, pend_next;
  logic [1:0]       pend_type [N_BTN];
  logic [1:0]       pend_type_next [N_BTN];
  logic [IDX_W-1:0] rr_ptr;

  logic             load;
  logic             found, found_hi, found_lo;
  logic [IDX_W-1:0] sel, sel_hi, sel_lo;
  logic [1:0]       sel_type, type_hi, type_lo;
  logic [N_BTN-1:0] grant;
  logic             drop_next;

  // Scan from rr_ptr upward with wrap: the first pending entry at or above
  // rr_ptr wins; failing that, the lowest pending entry below rr_ptr.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    sel_hi   = '0;
    sel_lo   = '0;
    type_hi  = EVT_PRESS;
    type_lo  = EVT_PRESS;
    for (int j = 0; j < N_BTN; j++) begin
      if (pend[j]) begin
        if (j >= int'(rr_ptr)) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            sel_hi   = IDX_W'(j);
            type_hi  = pend_type[j];
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          sel_lo   = IDX_W'(j);
          type_lo  = pend_type[j];
        end
      end
    end
    found    = found_hi | found_lo;
    sel      = found_hi ? sel_hi : sel_lo;
    sel_type = found_hi ? type_hi : type_lo;
    load     = !evt_valid || evt_ready;
    grant    = '0;
    if (load && found) grant[sel] = 1'b1;
  end

  // A grant frees its entry in the same cycle, so a new event for that
  // button is stored rather than dropped.
  always_comb begin
    pend_next = '0;
    drop_next = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      pend_type_next[i] = pend_type[i];
      pend_next[i]      = fsm_strobe[i] | (pend[i] & !grant[i]);
      if (fsm_strobe[i]) begin
        if (pend[i] && !grant[i]) drop_next = 1'b1;
        else                      pend_type_next[i] = fsm_type[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      rr_ptr    <= '0;
      evt_valid <= 1'b0;
      evt_btn   <= '0;
      evt_type  <= EVT_PRESS;
      evt_drop  <= 1'b0;
      for (int i = 0; i < N_BTN; i++) pend_type[i] <= EVT_PRESS;
    end else begin
      pend     <= pend_next;
      evt_drop <= drop_next;
      for (int i = 0; i < N_BTN; i++) pend_type[i] <= pend_type_next[i];
      if (load) begin
        evt_valid <= found;
        if (found) begin
          evt_btn  <= sel;
          evt_type <= sel_type;
          rr_ptr   <= (sel == IDX_LAST) ? '0 : sel + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_event_arbiter.sv
module tb_btn_event_arbiter;

  localparam int N_BTN        = 4;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam int LONG_TICKS   = 10;
  localparam int PRESS   = 0;
  localparam int RELEASE = 1;
  localparam int LONG    = 2;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [3:0]       btn = '0;
  logic             evt_ready = 1'b0;
  logic [3:0]       btn_level;
  logic             evt_valid;
  logic [1:0]       evt_btn;
  logic [1:0]       evt_type;
  logic             evt_drop;

  always #5 clk = ~clk;

  btn_event_arbiter #(
    .N_BTN       (N_BTN),
    .TICK_DIV    (TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS),
    .LONG_TICKS  (LONG_TICKS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_btn  (evt_btn),
    .evt_type (evt_type),
    .evt_drop (evt_drop)
  );

  // ---------------- bookkeeping ----------------
  int    n_checks = 0;
  int    n_err = 0;
  string phase = "init";
  int    cyc = 0;
  int    drop_cnt = 0;
  int    valid_cnt = 0;
  int    lvl0_rises = 0;
  logic  prev_lvl0 = 1'b0;

  logic [3:0] exp_q[$];
  logic [3:0] acc_q[$];
  int         acc_cyc[$];

  // ---------------- reference model ----------------
  // Debounce viewed as "run of ticks disagreeing with the committed level";
  // long press as "ticks held since the press (or since a bounce back)".
  bit m_sync1 [N_BTN];
  bit m_sync2 [N_BTN];
  int m_level [N_BTN];
  int m_run   [N_BTN];
  int m_hold  [N_BTN];
  int m_long  [N_BTN];
  int m_pend  [N_BTN];   // -1 = empty, else event type
  int m_div;
  bit m_valid;
  int m_sbtn;
  int m_stype;
  int m_rr;
  bit m_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ev(input int b, input int t);
    return {2'(b), 2'(t)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_BTN; i++) begin
      m_sync1[i] = 0; m_sync2[i] = 0;
      m_level[i] = 0; m_run[i] = 0; m_hold[i] = 0; m_long[i] = 0;
      m_pend[i] = -1;
    end
    m_div = 0; m_valid = 0; m_sbtn = 0; m_stype = 0; m_rr = 0; m_drop = 0;
  endtask

  task automatic model_step();
    int ev_t [N_BTN];
    bit s;
    bit tick;
    int j;
    int rr0;
    tick = (m_div == TICK_DIV - 1);
    for (int i = 0; i < N_BTN; i++) begin
      ev_t[i] = -1;
      if (tick) begin
        s = m_sync2[i];
        if (int'(s) != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == STABLE_TICKS) begin
            m_level[i] = int'(s);
            m_run[i] = 0;
            if (s) begin
              ev_t[i] = PRESS; m_hold[i] = 0; m_long[i] = 0;
            end else begin
              ev_t[i] = RELEASE;
            end
          end
        end else begin
          if (s) begin
            if (m_run[i] > 0) m_hold[i] = 0;
            else if (m_long[i] == 0) begin
              m_hold[i]++;
              if (m_hold[i] == LONG_TICKS) begin
                ev_t[i] = LONG; m_long[i] = 1;
              end
            end
          end
          m_run[i] = 0;
        end
      end
    end
    m_drop = 0;
    if (!m_valid || evt_ready) begin
      m_valid = 0;
      rr0 = m_rr;
      for (int k = 0; k < N_BTN; k++) begin
        j = (rr0 + k) % N_BTN;
        if (!m_valid && m_pend[j] >= 0) begin
          m_valid = 1; m_sbtn = j; m_stype = m_pend[j];
          m_pend[j] = -1; m_rr = (j + 1) % N_BTN;
        end
      end
    end
    for (int i = 0; i < N_BTN; i++) begin
      if (ev_t[i] >= 0) begin
        if (m_pend[i] >= 0) m_drop = 1;
        else                m_pend[i] = ev_t[i];
      end
      m_sync2[i] = m_sync1[i];
      m_sync1[i] = btn[i];
    end
    m_div = (m_div + 1) % TICK_DIV;
  endtask

  task automatic check_outputs();
    logic [3:0] lvl;
    for (int i = 0; i < N_BTN; i++) lvl[i] = m_level[i][0];
    check("level", btn_level, lvl);
    check("valid", evt_valid, m_valid);
    if (m_valid) begin
      check("btn", evt_btn, m_sbtn);
      check("type", evt_type, m_stype);
    end
    check("drop", evt_drop, m_drop);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".level"}, btn_level, 0);
    check({tag, ".valid"}, evt_valid, 0);
    check({tag, ".btn"}, evt_btn, 0);
    check({tag, ".type"}, evt_type, 0);
    check({tag, ".drop"}, evt_drop, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    if (evt_valid && evt_ready) begin
      acc_q.push_back({evt_btn, evt_type});
      acc_cyc.push_back(cyc);
    end
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (evt_drop) drop_cnt++;
    if (evt_valid) valid_cnt++;
    if (btn_level[0] && !prev_lvl0) lvl0_rises++;
    prev_lvl0 = btn_level[0];
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("reset_async");
    @(posedge clk);
    #1;
    check_zero("reset_hold");
    rst_n = 1'b1;
    prev_lvl0 = 1'b0;
  endtask

  task automatic clear_events();
    acc_q.delete(); acc_cyc.delete(); exp_q.delete();
    drop_cnt = 0; valid_cnt = 0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic compare_events(input string tag);
    logic [3:0] a;
    check({tag, ".count"}, acc_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      a = (k < acc_q.size()) ? acc_q[k] : 4'hx;
      check($sformatf("%s.ev%0d", tag, k), a, exp_q[k]);
    end
  endtask

  function automatic int gap(input int a, input int b);
    if (acc_cyc.size() > b) return acc_cyc[b] - acc_cyc[a];
    return -1;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    #2;
    phase = "reset";
    apply_reset();

    // Clean press on btn[1]
    phase = "clean";
    clear_events();
    evt_ready = 1'b1;
    btn[1] = 1'b1;
    run(80);
    exp_q.push_back(ev(1, PRESS));
    exp_q.push_back(ev(1, LONG));
    compare_events("press_long");
    check("valid_cycles", valid_cnt, 2);
    btn[1] = 1'b0;
    run(30);
    exp_q.push_back(ev(1, RELEASE));
    compare_events("release");

    // Bounce on btn[0]
    phase = "bounce";
    clear_events();
    lvl0_rises = 0;
    for (int c = 0; c < 40; c++) begin
      btn[0] = ((c / 5) % 2 == 0);
      cycle();
    end
    check("no_evt_bouncing", acc_q.size(), 0);
    btn[0] = 1'b1;
    run(40);
    exp_q.push_back(ev(0, PRESS));
    compare_events("bounce_press");
    check("level0_rises", lvl0_rises, 1);
    btn[0] = 1'b0;
    run(30);

    // Round robin
    phase = "rr";
    apply_reset();
    clear_events();
    evt_ready = 1'b1;
    btn[0] = 1'b1; btn[2] = 1'b1;
    run(30);
    btn[0] = 1'b0; btn[2] = 1'b0;
    run(30);
    btn[3] = 1'b1; btn[0] = 1'b1;
    run(30);
    btn[3] = 1'b0; btn[0] = 1'b0;
    run(30);
    exp_q.push_back(ev(0, PRESS));   exp_q.push_back(ev(2, PRESS));
    exp_q.push_back(ev(0, RELEASE)); exp_q.push_back(ev(2, RELEASE));
    exp_q.push_back(ev(3, PRESS));   exp_q.push_back(ev(0, PRESS));
    exp_q.push_back(ev(3, RELEASE)); exp_q.push_back(ev(0, RELEASE));
    compare_events("rr_order");
    check("rr_pair1_gap", gap(0, 1), 1);
    check("rr_pair2_gap", gap(4, 5), 1);

    // Backpressure
    phase = "backpressure";
    clear_events();
    evt_ready = 1'b0;
    btn[1] = 1'b1;
    run(30);
    btn[1] = 1'b0;
    run(30);
    check("held_valid", evt_valid, 1);
    check("held_btn", evt_btn, 1);
    check("held_type", evt_type, PRESS);
    evt_ready = 1'b1;
    run(5);
    exp_q.push_back(ev(1, PRESS));
    exp_q.push_back(ev(1, RELEASE));
    compare_events("bp");
    check("bp_gap", gap(0, 1), 1);
    check("bp_drops", drop_cnt, 0);

    // Drop
    phase = "drop";
    clear_events();
    evt_ready = 1'b0;
    btn[1] = 1'b1;
    run(70);
    btn[1] = 1'b0;
    run(30);
    btn[1] = 1'b1;
    run(30);
    evt_ready = 1'b1;
    run(5);
    exp_q.push_back(ev(1, PRESS));
    exp_q.push_back(ev(1, LONG));
    compare_events("drop_delivered");
    check("drop_pulses", drop_cnt, 2);
    btn[1] = 1'b0;
    run(30);

    // Reset while btn[2] is long-held
    phase = "reset_mid";
    clear_events();
    evt_ready = 1'b0;
    btn[2] = 1'b1;
    run(70);
    check("pre_reset_valid", evt_valid, 1);
    apply_reset();
    evt_ready = 1'b1;
    run(30);
    exp_q.push_back(ev(2, PRESS));
    compare_events("fresh_press");
    btn[2] = 1'b0;
    run(30);

    // Randomized traffic against the model
    phase = "random";
    clear_events();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N_BTN; i++)
        if ($urandom_range(0, 39) < 2) btn[i] = ~btn[i];
      evt_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    btn = '0;
    evt_ready = 1'b1;
    run(60);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
